// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: ALUOp/funct codes, FSM states
// and the decoded-operation enum passed between decode and the mul/div unit.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  function automatic logic is_muldiv(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M datapath: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, sign applied to the final value.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  op_e             op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [2*XLEN-1:0] r_p;
  logic [XLEN-1:0] r_m;
  logic            r_div;
  logic            r_hi;
  logic            r_neg;

  logic            w_sa, w_sb, w_is_div, w_hi, w_neg;
  logic [XLEN-1:0] w_ma, w_mb;
  logic [XLEN:0]   w_sum, w_trial;
  logic [2*XLEN-1:0] w_p_step, w_prod;
  logic [XLEN-1:0] w_sel;

  always_comb begin
    w_sa     = (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[XLEN-1];
    w_sb     = (op inside {OP_MULH, OP_DIV, OP_REM}) && b[XLEN-1];
    w_ma     = w_sa ? -a : a;
    w_mb     = w_sb ? -b : b;
    w_is_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    w_hi     = op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
    // remainder takes the dividend's sign; everything else the xor of both
    w_neg    = (op == OP_REM) ? w_sa : (w_sa ^ w_sb);
  end

  // mul: P = {acc, multiplier}; div: P = {partial remainder, dividend/quotient}
  always_comb begin
    w_sum   = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_m} : '0);
    w_trial = r_p[2*XLEN-1:XLEN-1] - {1'b0, r_m};
    if (r_div) begin
      if (w_trial[XLEN]) w_p_step = {r_p[2*XLEN-2:0], 1'b0};
      else               w_p_step = {w_trial[XLEN-1:0], r_p[XLEN-2:0], 1'b1};
    end else begin
      w_p_step = {w_sum, r_p[XLEN-1:1]};
    end
  end

  always_comb begin
    w_prod = r_neg ? -w_p_step : w_p_step;
    w_sel  = r_hi ? w_p_step[2*XLEN-1:XLEN] : w_p_step[XLEN-1:0];
    if (r_div) result = r_neg ? -w_sel : w_sel;
    else       result = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
  end

  // done marks the cycle whose step is the last; result is taken on that edge
  assign done = r_busy && (r_cnt == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_p    <= '0;
      r_m    <= '0;
      r_div  <= 1'b0;
      r_hi   <= 1'b0;
      r_neg  <= 1'b0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_p    <= {{XLEN{1'b0}}, (w_is_div ? w_ma : w_mb)};
      r_m    <= w_is_div ? w_mb : w_ma;
      r_div  <= w_is_div;
      r_hi   <= w_hi;
      r_neg  <= w_neg;
    end else if (r_busy) begin
      r_p   <= w_p_step;
      r_cnt <= r_cnt + CW'(1);
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle RV32I ops, iterative RV32M mul/div,
// valid/ready handshakes on both sides and a registered zero flag.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] read_data1,
  input  logic [XLEN-1:0] read_data2,
  input  logic [XLEN-1:0] imm32,
  input  logic            alu_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero
);

  state_e          r_state, w_state_nxt;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  op_e             w_op;
  logic [XLEN-1:0] w_b, w_alu_res, w_special_res, w_single_res, w_md_res;
  logic [SHW-1:0]  w_shamt;
  logic            w_special, w_md, w_accept, w_md_done, w_b_zero, w_ovf;

  always_comb begin
    w_op = OP_ADD;
    unique case (alu_op)
      ALUOP_ADD: w_op = OP_ADD;
      ALUOP_SUB: w_op = OP_SUB;
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        if (alu_op == ALUOP_RTYPE && funct7 == F7_MEXT) begin
          unique case (funct3)
            F3_MUL:    w_op = OP_MUL;
            F3_MULH:   w_op = OP_MULH;
            F3_MULHSU: w_op = OP_MULHSU;
            F3_MULHU:  w_op = OP_MULHU;
            F3_DIV:    w_op = OP_DIV;
            F3_DIVU:   w_op = OP_DIVU;
            F3_REM:    w_op = OP_REM;
            F3_REMU:   w_op = OP_REMU;
          endcase
        end else begin
          unique case (funct3)
            F3_ADD:  w_op = (alu_op == ALUOP_RTYPE && funct7[5]) ? OP_SUB : OP_ADD;
            F3_SLL:  w_op = OP_SLL;
            F3_SLT:  w_op = OP_SLT;
            F3_SLTU: w_op = OP_SLTU;
            F3_XOR:  w_op = OP_XOR;
            F3_SR:   w_op = funct7[5] ? OP_SRA : OP_SRL;
            F3_OR:   w_op = OP_OR;
            F3_AND:  w_op = OP_AND;
          endcase
        end
      end
    endcase
  end

  assign w_b     = alu_src ? imm32 : read_data2;
  assign w_shamt = w_b[SHW-1:0];

  always_comb begin
    w_alu_res = '0;
    case (w_op)
      OP_ADD:  w_alu_res = read_data1 + w_b;
      OP_SUB:  w_alu_res = read_data1 - w_b;
      OP_SLL:  w_alu_res = read_data1 << w_shamt;
      OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(read_data1) < $signed(w_b))};
      OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (read_data1 < w_b)};
      OP_XOR:  w_alu_res = read_data1 ^ w_b;
      OP_SRL:  w_alu_res = read_data1 >> w_shamt;
      OP_SRA:  w_alu_res = $signed(read_data1) >>> w_shamt;
      OP_OR:   w_alu_res = read_data1 | w_b;
      OP_AND:  w_alu_res = read_data1 & w_b;
      default: w_alu_res = '0;
    endcase
  end

  // divide-by-zero and signed overflow finish in one cycle without the iterator
  assign w_b_zero = (w_b == '0);
  assign w_ovf    = (read_data1 == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1);

  always_comb begin
    w_special     = 1'b0;
    w_special_res = '0;
    case (w_op)
      OP_DIV, OP_DIVU: begin
        if (w_b_zero) begin
          w_special     = 1'b1;
          w_special_res = '1;
        end else if (w_op == OP_DIV && w_ovf) begin
          w_special     = 1'b1;
          w_special_res = read_data1;
        end
      end
      OP_REM, OP_REMU: begin
        if (w_b_zero) begin
          w_special     = 1'b1;
          w_special_res = read_data1;
        end else if (w_op == OP_REM && w_ovf) begin
          w_special     = 1'b1;
          w_special_res = '0;
        end
      end
      default: begin
        w_special     = 1'b0;
        w_special_res = '0;
      end
    endcase
  end

  assign w_single_res = w_special ? w_special_res : w_alu_res;
  assign w_md         = is_muldiv(w_op) && !w_special;
  assign w_accept     = in_valid && (r_state == ST_IDLE) && !flush;

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .abort  (flush),
    .start  (w_accept && w_md),
    .op     (w_op),
    .a      (read_data1),
    .b      (w_b),
    .done   (w_md_done),
    .result (w_md_res)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_md ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_md_done) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept && !w_md) begin
      r_result <= w_single_res;
      r_zero   <= (w_single_res == '0);
    end else if (r_state == ST_BUSY && w_md_done && !flush) begin
      r_result <= w_md_res;
      r_zero   <= (w_md_res == '0);
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign alu_result = r_result;
  assign zero       = r_zero;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table for results/latency plus
// sequences for backpressure, flush, reset and kill-on-accept.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, alu_src;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] read_data1, read_data2, imm32;
  logic        in_ready, out_valid, zero;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, imm;
    logic        src;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_multicycle #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7     (funct7),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .imm32      (imm32),
    .alu_src    (alu_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string nm, input logic [1:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic src, input logic [31:0] exp,
                               input int lat);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
    v.imm = imm; v.src = src; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  function automatic void add(input vec_t v);
    vecs.push_back(v);
  endfunction

  // present one op, let it be accepted on the next edge, then scramble inputs
  task automatic start_op(input vec_t v);
    @(negedge clk);
    alu_op = v.op; funct3 = v.f3; funct7 = v.f7;
    read_data1 = v.a; read_data2 = v.b; imm32 = v.imm; alu_src = v.src;
    in_valid = 1'b1;
    check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    read_data1 = $urandom; read_data2 = $urandom; imm32 = $urandom;
    funct3 = 3'($urandom); funct7 = 7'($urandom); alu_op = 2'($urandom);
  endtask

  task automatic wait_valid(output int lat, output logic rdy_seen);
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   lat;
    logic rdy_seen;
    start_op(v);
    wait_valid(lat, rdy_seen);
    check({v.name, "_latency"}, 32'(lat), 32'(v.lat));
    check({v.name, "_result"}, alu_result, v.exp);
    check({v.name, "_zero"}, 32'(zero), 32'(v.exp == 32'd0));
    check({v.name, "_ready_in_done"}, 32'(in_ready), 32'd0);
    if (v.lat > 1) check({v.name, "_ready_in_busy"}, 32'(rdy_seen), 32'd0);
    take_result();
    check({v.name, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  task automatic abort_div(input logic use_rst);
    logic seen;
    start_op(mkv("abort_div", 2'b10, 3'b100, 7'h01, 32'd100, 32'd7, 32'd0, 1'b0, 32'd0, 33));
    repeat (9) @(posedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    check(use_rst ? "rst_busy_valid" : "flush_busy_valid", 32'(out_valid), 32'd0);
    check(use_rst ? "rst_busy_ready" : "flush_busy_ready", 32'(in_ready), 32'd1);
    if (use_rst) check("rst_busy_result", alu_result, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check(use_rst ? "rst_no_late_valid" : "flush_no_late_valid", 32'(seen), 32'd0);
    run_vec(mkv(use_rst ? "add_after_rst" : "add_after_flush", 2'b00, 3'b000, 7'h00,
                32'd40, 32'd2, 32'd0, 1'b0, 32'd42, 1));
    run_vec(mkv("divu_after_abort", 2'b10, 3'b101, 7'h01, 32'd100, 32'd7, 32'd0, 1'b0, 32'd14, 33));
  endtask

  initial begin
    vec_t bp;
    int   lat;
    logic rdy_seen;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alu_src = 1'b0;
    alu_op = '0; funct3 = '0; funct7 = '0; read_data1 = '0; read_data2 = '0; imm32 = '0;

    add(mkv("add_imm",    2'b00, 3'b000, 7'h00, 32'h10,       32'h0,        32'hFFFFFFFC, 1'b1, 32'h0000000C, 1));
    add(mkv("sub_eq",     2'b01, 3'b000, 7'h00, 32'h1234,     32'h1234,     32'h0,        1'b0, 32'h00000000, 1));
    add(mkv("sra",        2'b10, 3'b101, 7'h20, 32'h80000000, 32'd4,        32'h0,        1'b0, 32'hF8000000, 1));
    add(mkv("sltu",       2'b10, 3'b011, 7'h00, 32'd1,        32'hFFFFFFFF, 32'h0,        1'b0, 32'h00000001, 1));
    add(mkv("slt",        2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b0, 32'h00000001, 1));
    add(mkv("sub_r",      2'b10, 3'b000, 7'h20, 32'd5,        32'd7,        32'h0,        1'b0, 32'hFFFFFFFE, 1));
    add(mkv("addi_f7",    2'b11, 3'b000, 7'h20, 32'd5,        32'd0,        32'd7,        1'b1, 32'd12,       1));
    add(mkv("addi_mext",  2'b11, 3'b000, 7'h01, 32'd5,        32'd0,        32'd3,        1'b1, 32'd8,        1));
    add(mkv("srl",        2'b10, 3'b101, 7'h00, 32'h80000000, 32'h24,       32'h0,        1'b0, 32'h08000000, 1));
    add(mkv("srai",       2'b11, 3'b101, 7'h20, 32'hF0000000, 32'd0,        32'd8,        1'b1, 32'hFFF00000, 1));
    add(mkv("slli",       2'b11, 3'b001, 7'h00, 32'd1,        32'd0,        32'd31,       1'b1, 32'h80000000, 1));
    add(mkv("xor",        2'b10, 3'b100, 7'h00, 32'hF0F0,     32'hFF00,     32'h0,        1'b0, 32'h00000FF0, 1));
    add(mkv("or",         2'b10, 3'b110, 7'h00, 32'hF0F0,     32'hFF00,     32'h0,        1'b0, 32'h0000FFF0, 1));
    add(mkv("and",        2'b10, 3'b111, 7'h00, 32'hF0F0,     32'hFF00,     32'h0,        1'b0, 32'h0000F000, 1));
    add(mkv("mul",        2'b10, 3'b000, 7'h01, 32'hFFFFFFFF, 32'd2,        32'h0,        1'b0, 32'hFFFFFFFE, 33));
    add(mkv("mulh",       2'b10, 3'b001, 7'h01, 32'hFFFFFFFF, 32'd2,        32'h0,        1'b0, 32'hFFFFFFFF, 33));
    add(mkv("mulhsu",     2'b10, 3'b010, 7'h01, 32'hFFFFFFFF, 32'd2,        32'h0,        1'b0, 32'hFFFFFFFF, 33));
    add(mkv("mulhu",      2'b10, 3'b011, 7'h01, 32'hFFFFFFFF, 32'd2,        32'h0,        1'b0, 32'h00000001, 33));
    add(mkv("mulhu_max",  2'b10, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, 32'hFFFFFFFE, 33));
    add(mkv("mul_neg",    2'b10, 3'b000, 7'h01, 32'd7,        32'hFFFFFFFD, 32'h0,        1'b0, 32'hFFFFFFEB, 33));
    add(mkv("div",        2'b10, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd2,        32'h0,        1'b0, 32'hFFFFFFFD, 33));
    add(mkv("rem",        2'b10, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd2,        32'h0,        1'b0, 32'hFFFFFFFF, 33));
    add(mkv("divu",       2'b10, 3'b101, 7'h01, 32'hFFFFFFFF, 32'h10,       32'h0,        1'b0, 32'h0FFFFFFF, 33));
    add(mkv("remu",       2'b10, 3'b111, 7'h01, 32'd20,       32'd6,        32'h0,        1'b0, 32'h00000002, 33));
    add(mkv("divu_by0",   2'b10, 3'b101, 7'h01, 32'd7,        32'd0,        32'h0,        1'b0, 32'hFFFFFFFF, 1));
    add(mkv("rem_by0",    2'b10, 3'b110, 7'h01, 32'h1234,     32'd0,        32'h0,        1'b0, 32'h00001234, 1));
    add(mkv("rem_ovf",    2'b10, 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 32'h00000000, 1));
    add(mkv("div_ovf",    2'b10, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 32'h80000000, 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid_during", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", alu_result, 32'd0);
    check("reset_zero", 32'(zero), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // backpressure: result held while out_ready is low, no accept meanwhile
    bp = mkv("bp_add", 2'b00, 3'b000, 7'h00, 32'd3, 32'd4, 32'd0, 1'b0, 32'd7, 1);
    start_op(bp);
    wait_valid(lat, rdy_seen);
    check("bp_latency", 32'(lat), 32'd1);
    @(negedge clk);
    alu_op = 2'b01; read_data1 = 32'd9; read_data2 = 32'd9; alu_src = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", alu_result, 32'd7);
      check("bp_zero", 32'(zero), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_idle", {30'd0, in_ready, out_valid}, 32'b10);
    check("bp_release_result", alu_result, 32'd7);

    // flush together with in_valid in IDLE must not accept
    @(negedge clk);
    alu_op = 2'b00; read_data1 = 32'd1; read_data2 = 32'd1; alu_src = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_valid", 32'(out_valid), 32'd0);
    check("flush_accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("flush_accept_valid2", 32'(out_valid), 32'd0);

    abort_div(1'b0);
    abort_div(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
